block_plotter: RTL and testbench
================================

Name: block_plotter

Overview:
- Pixel-generating datapath that answers the game control FSM's plot/erase requests.
- Latches a block origin and colour, then walks a BLOCK_W x BLOCK_H rectangle one pixel per clock while plot_en is held.
- Drives x/y/colour toward the VGA adapter and raises done_plot so the control FSM can leave its PLOT or ERASE state.

Parameters:
- BLOCK_W, 4, block width in pixels (>=1)
- BLOCK_H, 4, block height in pixels (>=1)
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- ld_x  in  1  load x_in into origin X
- ld_y  in  1  load y_in and colour_in into origin Y / colour register
- x_in  in  X_W  new origin x
- y_in  in  Y_W  new origin y
- colour_in  in  3  block colour
- plot_en  in  1  plot request; level, held by control until done_plot
- erase_en  in  1  erase mode; output colour forced to 3'b000
- x_out  out  X_W  current pixel x
- y_out  out  Y_W  current pixel y
- colour_out  out  3  current pixel colour
- pixel_valid  out  1  current pixel is on-screen and must be written
- done_plot  out  1  rectangle finished; held until plot_en drops

Behaviour:
- Reset values:
  - origin x/y = 0, colour reg = 0, cx = cy = 0, state = IDLE.
  - x_out = 0, y_out = 0, colour_out = 0, pixel_valid = 0, done_plot = 0.
- Loads:
  - ld_x / ld_y take effect on the next clock only in IDLE.
  - Loads in DRAW or DONE are ignored, so the origin is frozen during a draw.
- Counters:
  - cx has $clog2(BLOCK_W) bits (min 1); cy has $clog2(BLOCK_H) bits (min 1).
  - x_out = origin_x + cx and y_out = origin_y + cy, combinational from registers, truncated to X_W / Y_W.
- FSM:
  - IDLE: outputs idle (pixel_valid = 0, done_plot = 0). plot_en = 1 -> DRAW with cx = cy = 0.
  - DRAW: one pixel per cycle, row-major.
    - cx increments each cycle; at cx = BLOCK_W-1 it wraps to 0 and cy increments.
    - pixel_valid = 1 iff x_out < SCREEN_W and y_out < SCREEN_H; no arithmetic wrap checking beyond this.
    - After the pixel (BLOCK_W-1, BLOCK_H-1) is presented -> DONE.
  - DONE: done_plot = 1, pixel_valid = 0, x/y outputs hold the last pixel. plot_en = 0 -> IDLE; otherwise stay in DONE.
- Latency: plot_en sampled high in IDLE at edge N gives pixel (0,0) during cycle N+1, the last pixel during cycle N+W*H, and done_plot from cycle N+W*H+1.
- Abort: plot_en = 0 in DRAW -> IDLE next edge, counters cleared, done_plot never asserted.
- colour_out = erase_en ? 3'b000 : colour reg; erase_en is sampled every cycle.
- BLOCK_W = BLOCK_H = 1: exactly one DRAW cycle, then DONE.
- resetn mid-DRAW or mid-DONE: everything returns to reset values on that edge; the in-flight draw is lost.

Optional Feature:
- BLOCK_PLOTTER_OUTLINE_EN defined:
  - Edge pixels (cx = 0, cx = BLOCK_W-1, cy = 0, cy = BLOCK_H-1) output ~colour reg.
  - Interior pixels output colour reg.
  - erase_en still forces 3'b000 everywhere.
- Undefined: uniform colour reg fill.

Test Plan:
- Reset, ld_x = ld_y = 1 with x_in = 10, y_in = 20, colour_in = 3'b100, then plot_en = 1 -> 16 pixels (10..13, 20..23) row-major, pixel_valid = 1, colour 3'b100, done_plot at cycle 17, IDLE one cycle after plot_en drops.
- Same origin with erase_en = 1 -> identical coordinate sequence, colour_out = 3'b000, done_plot at cycle 17.
- Origin x = 158, y = 118 -> pixel_valid only for x in {158, 159} and y in {118, 119} (4 pixels), done_plot still at cycle 17.
- plot_en dropped after 5 DRAW cycles -> IDLE, done_plot stays 0; next plot restarts at (0,0) offset.
- ld_x with x_in = 50 pulsed during DRAW -> ignored, coordinates keep the old origin; resetn mid-DRAW -> all outputs 0 next cycle.
- With BLOCK_PLOTTER_OUTLINE_EN and colour 3'b001 -> 12 edge pixels 3'b110, 4 interior pixels 3'b001.

Source files
------------

// File: rtl/block_plotter.sv
// block_plotter
//
// Pixel generator for the game's plot/erase path. While the controller is
// idle it latches a block origin and a colour. When plot_en rises it walks a
// BLOCK_W x BLOCK_H rectangle in row-major order, one pixel per clock. Each
// pixel is offered to the VGA adapter as x/y/colour. When the last pixel has
// been shown it raises done_plot, so the control FSM can leave its PLOT or
// ERASE state.
//
// Ports:
//   clk         system clock
//   resetn      synchronous, active-high reset (the name is historical)
//   ld_x        load x_in into origin X (honoured only while idle)
//   ld_y        load y_in / colour_in into origin Y / colour (idle only)
//   x_in        new origin x
//   y_in        new origin y
//   colour_in   block colour
//   plot_en     plot request level, held by the controller until done_plot
//   erase_en    erase mode: forces colour_out to 3'b000
//   x_out       current pixel x (origin_x + cx, truncated)
//   y_out       current pixel y (origin_y + cy, truncated)
//   colour_out  current pixel colour
//   pixel_valid current pixel is on-screen and must be written
//   done_plot   rectangle finished; held until plot_en drops
//
// Optional feature: define BLOCK_PLOTTER_OUTLINE_EN to draw the edge pixels
// of the block in the inverted colour. The interior pixels keep the
// latched colour.

module block_plotter #(
    parameter int BLOCK_W  = 4,
    parameter int BLOCK_H  = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           ld_x,
    input  logic           ld_y,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [2:0]     colour_in,
    input  logic           plot_en,
    input  logic           erase_en,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour_out,
    output logic           pixel_valid,
    output logic           done_plot
);

    // Counter widths never drop below one bit, so a 1-pixel dimension still
    // has a legal counter.
    localparam int CX_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int CY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam logic [CX_W-1:0] CX_LAST = CX_W'(BLOCK_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(BLOCK_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t         state;
    logic [X_W-1:0] origin_x;
    logic [Y_W-1:0] origin_y;
    logic [2:0]     colour_reg;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic           last_pixel;
    logic [2:0]     fill_colour;

    assign last_pixel = (cx == CX_LAST) && (cy == CY_LAST);

    // Control FSM and datapath registers. The counters are left untouched
    // when moving DRAW -> DONE, so x/y keep showing the last pixel while
    // done_plot is high. Every exit back to IDLE clears the counters.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= IDLE;
            origin_x   <= '0;
            origin_y   <= '0;
            colour_reg <= '0;
            cx         <= '0;
            cy         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_x) begin
                        origin_x <= x_in;
                    end
                    if (ld_y) begin
                        origin_y   <= y_in;
                        colour_reg <= colour_in;
                    end
                    cx <= '0;
                    cy <= '0;
                    if (plot_en) begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (!plot_en) begin
                        state <= IDLE;
                        cx    <= '0;
                        cy    <= '0;
                    end else if (last_pixel) begin
                        state <= DONE;
                    end else if (cx == CX_LAST) begin
                        cx <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                DONE: begin
                    if (!plot_en) begin
                        state <= IDLE;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign x_out = origin_x + X_W'(cx);
    assign y_out = origin_y + Y_W'(cy);

    // Clipping is a plain bounds check on the truncated coordinates. Any
    // wrap-around caused by truncation is deliberately left alone.
    assign pixel_valid = (state == DRAW) &&
                         (32'(x_out) < SCREEN_W) &&
                         (32'(y_out) < SCREEN_H);
    assign done_plot   = (state == DONE);

`ifdef BLOCK_PLOTTER_OUTLINE_EN
    logic on_edge;
    assign on_edge     = (cx == '0) || (cx == CX_LAST) ||
                         (cy == '0) || (cy == CY_LAST);
    assign fill_colour = on_edge ? ~colour_reg : colour_reg;
`else
    assign fill_colour = colour_reg;
`endif

    assign colour_out = erase_en ? 3'b000 : fill_colour;

endmodule

// File: tb/tb_block_plotter.sv
// tb_block_plotter
//
// Self-checking bench for block_plotter. For every plot it builds the
// expected pixel list from the block geometry (row-major order, truncated
// coordinates, screen clipping, colour rules). It then compares that list
// with the DUT one cycle at a time. It runs the directed scenarios first
// (normal draw, erase, clipped corner, abort, frozen origin, mid-draw
// reset), followed by randomized plots.

module tb_block_plotter;

    localparam int BW = 4;
    localparam int BH = 4;
    localparam int SW = 160;
    localparam int SH = 120;
    localparam int XW = 8;
    localparam int YW = 7;

    logic          clk;
    logic          resetn;
    logic          ld_x;
    logic          ld_y;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic [2:0]    colour_in;
    logic          plot_en;
    logic          erase_en;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [2:0]    colour_out;
    logic          pixel_valid;
    logic          done_plot;

    int checks = 0;
    int errors = 0;

    block_plotter #(
        .BLOCK_W (BW),
        .BLOCK_H (BH),
        .SCREEN_W(SW),
        .SCREEN_H(SH),
        .X_W     (XW),
        .Y_W     (YW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .plot_en    (plot_en),
        .erase_en   (erase_en),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .pixel_valid(pixel_valid),
        .done_plot  (done_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference colour for pixel (i, j) of a block.
    function automatic logic [2:0] model_colour(input int i, input int j,
                                                input logic [2:0] col, input logic er);
        logic [2:0] c;
        c = col;
`ifdef BLOCK_PLOTTER_OUTLINE_EN
        if (i == 0 || i == BW - 1 || j == 0 || j == BH - 1) c = ~col;
`endif
        if (er) c = 3'b000;
        return c;
    endfunction

    task automatic check_idle(input string tag, input int ex, input int ey);
        check({tag, "_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_done"},  32'(done_plot),   32'd0);
        check({tag, "_x"},     32'(x_out),       32'(ex));
        check({tag, "_y"},     32'(y_out),       32'(ey));
    endtask

    // Load an origin and colour, then draw one block.
    //   er_mode : 0 = no erase, 1 = erase, 2 = random erase every cycle
    //   abort_at: drop plot_en after this many DRAW cycles (-1 = never)
    //   ld_at   : pulse ld_x (x_in = 50) after this pixel (-1 = never)
    //   rst_at  : pulse reset after this many DRAW cycles (-1 = never)
    task automatic run_plot(input int ox, input int oy, input logic [2:0] col,
                            input int er_mode, input int abort_at,
                            input int ld_at, input int rst_at);
        int px[$];
        int py[$];
        int lx;
        int ly;
        logic er;
        ld_x      = 1'b1;
        ld_y      = 1'b1;
        x_in      = XW'(ox);
        y_in      = YW'(oy);
        colour_in = col;
        tick();
        ld_x = 1'b0;
        ld_y = 1'b0;
        x_in = '0;
        y_in = '0;
        colour_in = ~col;
        for (int j = 0; j < BH; j++) begin
            for (int i = 0; i < BW; i++) begin
                px.push_back(i);
                py.push_back(j);
            end
        end
        plot_en  = 1'b1;
        erase_en = (er_mode == 1);
        tick();
        for (int k = 0; k < BW * BH; k++) begin
            int ex;
            int ey;
            if (k == abort_at) begin
                plot_en = 1'b0;
                tick();
                check_idle("abort", ox % 256, oy % 128);
                tick();
                return;
            end
            if (k == rst_at) begin
                resetn = 1'b1;
                tick();
                resetn  = 1'b0;
                plot_en = 1'b0;
                check_idle("midrst", 0, 0);
                check("midrst_colour", 32'(colour_out), 32'd0);
                tick();
                return;
            end
            er = (er_mode == 2) ? 1'($urandom_range(0, 1)) : (er_mode == 1);
            erase_en = er;
            #1;
            ex = (ox + px[k]) % 256;
            ey = (oy + py[k]) % 128;
            check("pix_x",      32'(x_out),       32'(ex));
            check("pix_y",      32'(y_out),       32'(ey));
            check("pix_valid",  32'(pixel_valid), 32'(ex < SW && ey < SH));
            check("pix_colour", 32'(colour_out),  32'(model_colour(px[k], py[k], col, er)));
            check("pix_done",   32'(done_plot),   32'd0);
            if (k == ld_at) begin
                ld_x = 1'b1;
                x_in = 8'd50;
            end
            tick();
            ld_x = 1'b0;
        end
        lx = (ox + BW - 1) % 256;
        ly = (oy + BH - 1) % 128;
        check("done_flag",  32'(done_plot),   32'd1);
        check("done_valid", 32'(pixel_valid), 32'd0);
        check("done_x",     32'(x_out),       32'(lx));
        check("done_y",     32'(y_out),       32'(ly));
        tick();
        check("done_hold",  32'(done_plot),   32'd1);
        plot_en = 1'b0;
        tick();
        check_idle("back_idle", ox % 256, oy % 128);
    endtask

    initial begin
        resetn    = 1'b1;
        ld_x      = 1'b0;
        ld_y      = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        plot_en   = 1'b0;
        erase_en  = 1'b0;
        tick();
        tick();
        check_idle("reset", 0, 0);
        check("reset_colour", 32'(colour_out), 32'd0);
        resetn = 1'b0;
        tick();

        $display("[TB] directed plots");
        run_plot(10, 20, 3'b100, 0, -1, -1, -1);
        run_plot(10, 20, 3'b100, 1, -1, -1, -1);
        run_plot(158, 118, 3'b010, 0, -1, -1, -1);
        run_plot(30, 40, 3'b011, 0, 5, -1, -1);
        run_plot(30, 40, 3'b011, 0, -1, -1, -1);
        run_plot(70, 60, 3'b101, 0, -1, 3, -1);
        run_plot(70, 60, 3'b111, 0, -1, -1, 3);
        run_plot(12, 12, 3'b001, 0, -1, -1, -1);

        $display("[TB] randomized plots");
        for (int n = 0; n < 20; n++) begin
            run_plot(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                     -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
